// File: rtl/serial_link_pwr_seq.sv
// Per-link power/isolation sequencer: clock gate, link reset and AXI isolation driven in a fixed order.
// Latency: outputs registered, updated on the edge that changes state; settle states dwell max(SettleCycles,1) cycles.
// Backpressure: DEISO/ISO wait for isolate acks; SERIAL_LINK_PWR_SEQ_TIMEOUT_EN adds an ack timeout into ERROR.
module serial_link_pwr_seq #(
  parameter int NumLinks      = 2,
  parameter int SettleCycles  = 8,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumLinks-1:0]   en_req_i,
  input  logic [NumLinks-1:0]   err_clr_i,
  input  logic [2*NumLinks-1:0] isolated_i,
  output logic [2*NumLinks-1:0] isolate_o,
  output logic [NumLinks-1:0]   clk_ena_o,
  output logic [NumLinks-1:0]   reset_no,
  output logic [NumLinks-1:0]   active_o,
  output logic [NumLinks-1:0]   busy_o,
  output logic [NumLinks-1:0]   err_o
);

  localparam int Settle = (SettleCycles < 1) ? 1 : SettleCycles;
  localparam int CntMax = (Settle > TimeoutCycles) ? Settle : TimeoutCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(Settle - 1);
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);
`else
  logic unused_err_clr;
  assign unused_err_clr = ^err_clr_i;
`endif

  typedef enum logic [3:0] {
    S_OFF, S_CLK_ON, S_RST_REL, S_DEISO, S_ACTIVE,
    S_ISO, S_RST_ASSERT, S_CLK_OFF, S_ERROR
  } state_e;

  for (genvar g = 0; g < NumLinks; g++) begin : g_link
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            count_en;
    logic [1:0]      ack;
    logic [1:0]      iso_d, iso_q;
    logic            clk_ena_d, rst_n_d, active_d, busy_d, err_d;
    logic            clk_ena_q, rst_n_q, active_q, busy_q, err_q;

    assign ack = isolated_i[2*g +: 2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= S_OFF;
        cnt_q     <= '0;
        iso_q     <= 2'b11;
        clk_ena_q <= 1'b0;
        rst_n_q   <= 1'b0;
        active_q  <= 1'b0;
        busy_q    <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        iso_q     <= iso_d;
        clk_ena_q <= clk_ena_d;
        rst_n_q   <= rst_n_d;
        active_q  <= active_d;
        busy_q    <= busy_d;
        err_q     <= err_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      count_en  = 1'b0;
      iso_d     = 2'b11;
      clk_ena_d = 1'b0;
      rst_n_d   = 1'b0;
      active_d  = 1'b0;
      busy_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
        S_OFF:        if (en_req_i[g]) state_d = S_CLK_ON;
        S_CLK_ON: begin
          count_en = 1'b1;
          if (cnt_q == SettleLast) state_d = S_RST_REL;
        end
        S_RST_REL: begin
          count_en = 1'b1;
          if (cnt_q == SettleLast) state_d = S_DEISO;
        end
        S_DEISO: begin
          if (ack == 2'b00) state_d = S_ACTIVE;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
          else if (cnt_q == TimeoutVal) state_d = S_ERROR;
          count_en = 1'b1;
`endif
        end
        S_ACTIVE:     if (!en_req_i[g]) state_d = S_ISO;
        S_ISO: begin
          if (ack == 2'b11) state_d = S_RST_ASSERT;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
          else if (cnt_q == TimeoutVal) state_d = S_ERROR;
          count_en = 1'b1;
`endif
        end
        S_RST_ASSERT: begin
          count_en = 1'b1;
          if (cnt_q == SettleLast) state_d = S_CLK_OFF;
        end
        S_CLK_OFF:    state_d = S_OFF;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
        S_ERROR:      if (err_clr_i[g]) state_d = S_OFF;
`else
        S_ERROR:      state_d = S_OFF;
`endif
        default:      state_d = S_OFF;
      endcase

      // Dwell counter restarts on every state entry and idles at zero elsewhere.
      cnt_d = (state_d != state_q || !count_en) ? '0 : cnt_q + CntW'(1);

      // Outputs are decoded from the next state so the registers change on the transition edge.
      unique case (state_d)
        S_CLK_ON:     begin clk_ena_d = 1'b1; busy_d = 1'b1; end
        S_RST_REL:    begin clk_ena_d = 1'b1; rst_n_d = 1'b1; busy_d = 1'b1; end
        S_DEISO:      begin clk_ena_d = 1'b1; rst_n_d = 1'b1; iso_d = 2'b00; busy_d = 1'b1; end
        S_ACTIVE:     begin clk_ena_d = 1'b1; rst_n_d = 1'b1; iso_d = 2'b00; active_d = 1'b1; end
        S_ISO:        begin clk_ena_d = 1'b1; rst_n_d = 1'b1; busy_d = 1'b1; end
        S_RST_ASSERT: begin clk_ena_d = 1'b1; busy_d = 1'b1; end
        S_CLK_OFF:    busy_d = 1'b1;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
        S_ERROR:      err_d = 1'b1;
`endif
        default:      ;
      endcase
    end

    assign isolate_o[2*g +: 2] = iso_q;
    assign clk_ena_o[g]        = clk_ena_q;
    assign reset_no[g]         = rst_n_q;
    assign active_o[g]         = active_q;
    assign busy_o[g]           = busy_q;
    assign err_o[g]            = err_q;
  end

endmodule

// File: tb/tb_serial_link_pwr_seq.sv
// Directed bench for serial_link_pwr_seq: link 0 is sequenced, link 1 must stay OFF throughout.
module tb_serial_link_pwr_seq;
  localparam int N       = 2;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
  localparam int HOLD = 12;
`else
  localparam int HOLD = 50;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0] en_req = '0;
  logic [N-1:0] err_clr = '0;
  logic [2*N-1:0] isolated;
  logic [2*N-1:0] isolate;
  logic [N-1:0] clk_ena, reset_n, active, busy, err;
  logic [2*N-1:0] iso_dly = 4'hF;
  logic force_ack = 1'b0;
  logic [1:0] forced_ack = 2'b00;
  logic [13:0] obs, exp;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) iso_dly <= isolate;
  assign isolated = {iso_dly[3:2], force_ack ? forced_ack : iso_dly[1:0]};
  assign obs = {isolate, clk_ena, reset_n, active, busy, err};

  serial_link_pwr_seq #(
    .NumLinks(N), .SettleCycles(SETTLE), .TimeoutCycles(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_req_i(en_req), .err_clr_i(err_clr),
    .isolated_i(isolated), .isolate_o(isolate), .clk_ena_o(clk_ena),
    .reset_no(reset_n), .active_o(active), .busy_o(busy), .err_o(err)
  );

  // Expected output word with link 1 held at its OFF values.
  function automatic logic [13:0] pack(input logic [1:0] iso0, input logic c, input logic r,
                                       input logic a, input logic b, input logic e);
    return {2'b11, iso0, 1'b0, c, 1'b0, r, 1'b0, a, 1'b0, b, 1'b0, e};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    exp = pack(2'b11, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset: got %b, expected %b", obs, exp); end
    en_req = 2'b01;
    tick;
    tick;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_hold: got %b, expected %b", obs, exp); end
    en_req = 2'b00;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_power_up;
    en_req = 2'b01;
    for (int i = 0; i <= 10; i++) begin
      tick;
      exp = pack((i >= 8) ? 2'b00 : 2'b11, 1, i >= 4, i >= 10, i < 10, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL up[%0d]: got %b, expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_power_down;
    en_req = 2'b00;
    for (int i = 0; i <= 7; i++) begin
      tick;
      exp = pack(2'b11, i < 6, i < 2, 0, i < 7, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL down[%0d]: got %b, expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_toggle_clk_on;
    en_req = 2'b01;
    for (int i = 0; i <= 10; i++) begin
      tick;
      exp = pack((i >= 8) ? 2'b00 : 2'b11, 1, i >= 4, i >= 10, i < 10, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL toggle_up[%0d]: got %b, expected %b", i, obs, exp); end
      en_req = (i == 1) ? 2'b01 : 2'b00;
    end
    for (int i = 0; i <= 7; i++) begin
      tick;
      exp = pack(2'b11, i < 6, i < 2, 0, i < 7, 0);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL toggle_down[%0d]: got %b, expected %b", i, obs, exp); end
    end
  endtask

  task automatic test_partial_ack;
    force_ack = 1'b1;
    forced_ack = 2'b01;
    en_req = 2'b01;
    repeat (9) tick;
    exp = pack(2'b00, 1, 1, 0, 1, 0);
    for (int h = 0; h < HOLD; h++) begin
      tick;
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL deiso_hold[%0d]: got %b, expected %b", h, obs, exp); end
    end
    forced_ack = 2'b00;
    tick;
    exp = pack(2'b00, 1, 1, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL deiso_ack: got %b, expected %b", obs, exp); end
    force_ack = 1'b0;
    en_req = 2'b00;
    repeat (8) tick;
    exp = pack(2'b11, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL partial_off: got %b, expected %b", obs, exp); end
  endtask

  task automatic test_async_reset;
    en_req = 2'b01;
    repeat (6) tick;
    exp = pack(2'b11, 1, 1, 0, 1, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL rst_rel: got %b, expected %b", obs, exp); end
    #2;
    rst_n = 1'b0;
    #1;
    exp = pack(2'b11, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL async_reset: got %b, expected %b", obs, exp); end
    en_req = 2'b00;
    tick;
    rst_n = 1'b1;
    tick;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL after_reset: got %b, expected %b", obs, exp); end
  endtask

`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
  task automatic test_timeout;
    en_req = 2'b01;
    repeat (11) tick;
    exp = pack(2'b00, 1, 1, 1, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL to_active: got %b, expected %b", obs, exp); end
    force_ack = 1'b1;
    forced_ack = 2'b00;
    en_req = 2'b00;
    for (int i = 0; i <= 17; i++) begin
      tick;
      exp = (i < 17) ? pack(2'b11, 1, 1, 0, 1, 0) : pack(2'b11, 0, 0, 0, 0, 1);
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL iso_timeout[%0d]: got %b, expected %b", i, obs, exp); end
    end
    en_req = 2'b01;
    tick;
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL error_hold: got %b, expected %b", obs, exp); end
    err_clr = 2'b01;
    tick;
    err_clr = 2'b00;
    exp = pack(2'b11, 0, 0, 0, 0, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL err_clr: got %b, expected %b", obs, exp); end
    tick;
    exp = pack(2'b11, 1, 0, 0, 1, 0);
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL restart: got %b, expected %b", obs, exp); end
    force_ack = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_power_up;
    test_power_down;
    test_toggle_clk_on;
    test_partial_ack;
    test_async_reset;
`ifdef SERIAL_LINK_PWR_SEQ_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
